// File: rtl/hwce_wl_fetch.sv
// Weight-load fetch unit: issues strided TCDM word reads under FIFO credit and
// streams the in-order responses to the HWCE datapath as a valid/ready stream.
module hwce_wl_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start_i,
   input  logic [ADDR_WIDTH-1:0]   base_addr_i,
   input  logic [CNT_WIDTH-1:0]    nb_words_i,
   input  logic [ADDR_WIDTH-1:0]   stride_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    tcdm_req_o,
   output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
   output logic                    tcdm_wen_o,
   output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
   output logic [DATA_WIDTH-1:0]   tcdm_wdata_o,
   input  logic                    tcdm_gnt_i,
   input  logic                    tcdm_r_valid_i,
   input  logic [DATA_WIDTH-1:0]   tcdm_r_rdata_i,
   output logic                    out_valid_o,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   input  logic                    out_ready_i
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [ADDR_WIDTH-1:0] stride;
   logic                  req;
   logic                  done;
   logic [CNT_WIDTH-1:0]  req_left;
   logic [CNT_WIDTH-1:0]  rsp_left;
   logic [CNT_WIDTH-1:0]  req_left_nxt;
   logic [OCC_W-1:0]      outstanding;
   logic [OCC_W-1:0]      occ_nxt;
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic [PTR_W:0]        fifo_count;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic                  fire;
   logic                  push;
   logic                  pop;
   logic                  credit;

   assign fire       = req & tcdm_gnt_i;
   assign push       = tcdm_r_valid_i & (outstanding != '0);
   assign pop        = out_valid_o & out_ready_i;
   assign fifo_count = wr_ptr - rd_ptr;

   // Occupancy the next cycle will see (buffered + in flight); a push only moves
   // a word from in-flight to buffered, so it does not appear here.
   always_comb begin
      req_left_nxt = req_left - CNT_WIDTH'(fire);
      occ_nxt      = OCC_W'(fifo_count) + outstanding + OCC_W'(fire) - OCC_W'(pop);
      credit       = occ_nxt < OCC_W'(FIFO_DEPTH);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         addr        <= '0;
         stride      <= '0;
         req         <= 1'b0;
         done        <= 1'b0;
         req_left    <= '0;
         rsp_left    <= '0;
         outstanding <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         done        <= (state == DONE);
         outstanding <= outstanding + OCC_W'(fire) - OCC_W'(push);
         wr_ptr      <= wr_ptr + {{PTR_W{1'b0}}, push};
         rd_ptr      <= rd_ptr + {{PTR_W{1'b0}}, pop};
         if (push && rsp_left != '0)
            rsp_left <= rsp_left - CNT_WIDTH'(1);
         case (state)
            IDLE: begin
               if (start_i) begin
                  addr     <= base_addr_i;
                  stride   <= stride_i;
                  req_left <= nb_words_i;
                  rsp_left <= nb_words_i;
                  if (nb_words_i == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     req   <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (fire)
                  addr <= addr + stride;
               req_left <= req_left_nxt;
               // An ungranted request keeps req/add frozen until the grant arrives.
               if (!req || tcdm_gnt_i)
                  req <= (req_left_nxt != '0) && credit;
               if (req_left_nxt == '0)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (rsp_left == '0 && fifo_count == '0)
                  state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_mem[wr_ptr[PTR_W-1:0]] <= tcdm_r_rdata_i;
   end

   assign busy_o       = (state == RUN) || (state == DRAIN);
   assign done_o       = done;
   assign tcdm_req_o   = req;
   assign tcdm_add_o   = addr;
   assign tcdm_wen_o   = 1'b1;
   assign tcdm_be_o    = '1;
   assign tcdm_wdata_o = '0;
   assign out_valid_o  = (fifo_count != '0);
   assign out_data_o   = fifo_mem[rd_ptr[PTR_W-1:0]];

   no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
      !(tcdm_r_valid_i && outstanding == '0));

endmodule

// File: tb/tb_hwce_wl_fetch.sv
// Randomized bench for hwce_wl_fetch: a TCDM slave with variable grant/latency
// and a queue-based model of the expected address and word streams.
module tb_hwce_wl_fetch;
   localparam int AW = 8;
   localparam int DW = 32;
   localparam int CW = 16;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [AW-1:0] base_addr_i;
   logic [CW-1:0] nb_words_i;
   logic [AW-1:0] stride_i;
   logic          busy_o, done_o, tcdm_req_o, tcdm_wen_o;
   logic [AW-1:0] tcdm_add_o;
   logic [DW/8-1:0] tcdm_be_o;
   logic [DW-1:0] tcdm_wdata_o;
   logic          tcdm_gnt_i, tcdm_r_valid_i;
   logic [DW-1:0] tcdm_r_rdata_i;
   logic          out_valid_o, out_ready_i;
   logic [DW-1:0] out_data_o;

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   hwce_wl_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .FIFO_DEPTH(FD)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start_i), .base_addr_i(base_addr_i),
      .nb_words_i(nb_words_i), .stride_i(stride_i), .busy_o(busy_o), .done_o(done_o),
      .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
      .tcdm_be_o(tcdm_be_o), .tcdm_wdata_o(tcdm_wdata_o), .tcdm_gnt_i(tcdm_gnt_i),
      .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_rdata_i(tcdm_r_rdata_i),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {24'd0, a} * 32'd3;
   endfunction

   // Model state: what the current job must still issue and deliver
   logic [AW-1:0] exp_addr_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [AW-1:0] addr_log[$];
   int            cyc_log[$];
   logic [DW-1:0] stream_log[$];
   int fire_cnt, granted, popped, done_cnt, done_cyc, first_valid_cyc, req_seen, job_cyc;
   int gnt_mode = 0;
   int ready_mode = 0;
   int lat_max = 1;

   // TCDM slave: in-order responses, each at least one cycle after its grant
   typedef struct {logic [DW-1:0] data; int due;} rsp_t;
   rsp_t rq[$];
   initial begin
      rsp_t r;
      tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b0; tcdm_r_rdata_i = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            rq.delete();
         end else begin
            if (tcdm_r_valid_i) rq.delete(0);
            if (tcdm_req_o && tcdm_gnt_i) begin
               r.data = mem_word(tcdm_add_o);
               r.due  = cyc + int'($urandom_range(1, lat_max));
               rq.push_back(r);
            end
         end
         @(posedge clk); #1;
         tcdm_r_valid_i = 1'b0;
         tcdm_r_rdata_i = '0;
         if (!rst && rq.size() > 0) begin
            if (rq[0].due <= cyc) begin
               tcdm_r_valid_i = 1'b1;
               tcdm_r_rdata_i = rq[0].data;
            end
         end
         tcdm_gnt_i = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   initial begin
      out_ready_i = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (ready_mode)
            0:       out_ready_i = 1'b1;
            1:       out_ready_i = 1'($urandom_range(0, 1));
            default: out_ready_i = 1'b0;
         endcase
      end
   end

   // Single compare process, sampling mid-cycle
   logic          hold_pend = 1'b0;
   logic [AW-1:0] hold_add;
   logic [AW-1:0] ea;
   logic [DW-1:0] ed;
   always @(negedge clk) begin
      if (rst) begin
         exp_addr_q.delete();
         exp_data_q.delete();
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("req_held", 64'(tcdm_req_o), 64'd1);
            chk("add_held", 64'(tcdm_add_o), 64'(hold_add));
         end
         if (tcdm_req_o) req_seen++;
         if (tcdm_req_o && tcdm_gnt_i) begin
            chk("credit", 64'(granted - popped < FD), 64'd1);
            if (exp_addr_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_req: got addr %0h, required no request", tcdm_add_o);
            end else begin
               ea = exp_addr_q.pop_front();
               chk("req_addr", 64'(tcdm_add_o), 64'(ea));
            end
            addr_log.push_back(tcdm_add_o);
            cyc_log.push_back(cyc);
            fire_cnt++;
            granted++;
         end
         hold_pend = tcdm_req_o && !tcdm_gnt_i;
         hold_add  = tcdm_add_o;
         if (out_valid_o) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (exp_data_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL extra_word: got %0h, required no word", out_data_o);
            end else begin
               chk("stream_data", 64'(out_data_o), 64'(exp_data_q[0]));
               if (out_ready_i) begin
                  ed = exp_data_q.pop_front();
                  stream_log.push_back(out_data_o);
                  popped++;
               end
            end
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 64'(busy_o), 64'd0);
            chk("words_left_at_done", 64'(exp_data_q.size()), 64'd0);
         end
      end
   end

   task automatic start_job(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [AW-1:0] s);
      logic [AW-1:0] a;
      a = b;
      for (int i = 0; i < int'(n); i++) begin
         exp_addr_q.push_back(a);
         exp_data_q.push_back(mem_word(a));
         a = a + s;
      end
      addr_log.delete(); cyc_log.delete(); stream_log.delete();
      fire_cnt = 0; granted = 0; popped = 0; done_cnt = 0; req_seen = 0;
      done_cyc = -1; first_valid_cyc = -1;
      job_cyc = cyc;
      start_i = 1'b1; base_addr_i = b; nb_words_i = n; stride_i = s;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input int nb);
      bit got;
      got = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #1;
         if (done_cnt > 0) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) begin
         tests++; fails++;
         $display("FAIL done_timeout: got no done_o, required one within %0d cycles", budget);
      end
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("words_issued", 64'(fire_cnt), 64'(nb));
      chk("words_delivered", 64'(stream_log.size()), 64'(nb));
      chk("busy_after_done", 64'(busy_o), 64'd0);
   endtask

   initial begin
      logic [AW-1:0] exp_a4 [4];
      logic [DW-1:0] exp_d4 [4];
      logic [AW-1:0] exp_a3 [3];
      logic [AW-1:0] rb, rs;
      logic [CW-1:0] rn;
      bit            hit;
      exp_a4 = '{8'h10, 8'h11, 8'h12, 8'h13};
      exp_d4 = '{32'h30, 32'h33, 32'h36, 32'h39};
      exp_a3 = '{8'hFE, 8'h01, 8'h04};

      rst = 1'b1; start_i = 1'b0; base_addr_i = '0; nb_words_i = '0; stride_i = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_done", 64'(done_o), 64'd0);
      chk("rst_req", 64'(tcdm_req_o), 64'd0);
      chk("rst_add", 64'(tcdm_add_o), 64'd0);
      chk("rst_out_valid", 64'(out_valid_o), 64'd0);
      chk("wen_read", 64'(tcdm_wen_o), 64'd1);
      chk("be_all", 64'(tcdm_be_o), 64'hF);
      chk("wdata_zero", 64'(tcdm_wdata_o), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic fetch
      start_job(8'h10, 16'd4, 8'd1);
      wait_done(60, 4);
      for (int i = 0; i < 4; i++) begin
         chk("basic_addr", 64'(addr_log[i]), 64'(exp_a4[i]));
         chk("basic_fire_cycle", 64'(cyc_log[i] - job_cyc), 64'(1 + i));
         chk("basic_word", 64'(stream_log[i]), 64'(exp_d4[i]));
      end
      chk("first_word_latency", 64'(first_valid_cyc - job_cyc), 64'd3);

      // Stride with address wrap
      start_job(8'hFE, 16'd3, 8'd3);
      wait_done(60, 3);
      for (int i = 0; i < 3; i++)
         chk("wrap_addr", 64'(addr_log[i]), 64'(exp_a3[i]));

      // Backpressure
      ready_mode = 2;
      start_job(8'h20, 16'd8, 8'd1);
      repeat (20) @(posedge clk);
      #1;
      chk("bp_grants", 64'(fire_cnt), 64'd4);
      chk("bp_req_low", 64'(tcdm_req_o), 64'd0);
      ready_mode = 0;
      wait_done(80, 8);

      // Grant stalls
      gnt_mode = 1;
      start_job(8'h50, 16'd16, 8'd1);
      wait_done(400, 16);
      gnt_mode = 0;

      // Zero length
      start_job(8'h33, 16'd0, 8'd1);
      wait_done(20, 0);
      chk("zero_done_latency", 64'(done_cyc - job_cyc), 64'd2);
      chk("zero_no_req", 64'(req_seen), 64'd0);

      // Start ignored while running
      ready_mode = 2;
      start_job(8'h40, 16'd6, 8'd2);
      repeat (2) @(posedge clk);
      #1;
      start_i = 1'b1; base_addr_i = 8'h80; nb_words_i = 16'd3; stride_i = 8'd5;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      ready_mode = 0;
      wait_done(80, 6);

      // Reset in the middle of a job
      start_job(8'h60, 16'd10, 8'd1);
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (fire_cnt >= 3) begin
            hit = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("rst_job_reached_3_grants", 64'(hit), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk("midrst_req", 64'(tcdm_req_o), 64'd0);
      chk("midrst_add", 64'(tcdm_add_o), 64'd0);
      chk("midrst_busy", 64'(busy_o), 64'd0);
      chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst_no_done", 64'(done_cnt), 64'd0);
      start_job(8'h70, 16'd2, 8'd1);
      wait_done(40, 2);

      // Randomized jobs
      for (int j = 0; j < 8; j++) begin
         gnt_mode   = int'($urandom_range(0, 1));
         ready_mode = int'($urandom_range(0, 1));
         lat_max    = int'($urandom_range(1, 3));
         rb = 8'($urandom);
         rn = 16'($urandom_range(1, 12));
         rs = 8'($urandom_range(0, 7));
         start_job(rb, rn, rs);
         wait_done(600, int'(rn));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
